// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// funct codes, ALU operation codes and datapath select encodings.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCB_RT       = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic funct_supported(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_NOR) || (f == FN_SLT);
  endfunction

  function automatic logic instr_supported(input logic [5:0] op, input logic [5:0] f);
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      OP_RTYPE:                            return funct_supported(f);
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the FSM's ALUOp and the instruction funct field to the ALU operation code.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [3:0] ALU_control
);

  always_comb begin
    ALU_control = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALU_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  ALU_control = ALU_SUB;
          FN_AND:  ALU_control = ALU_AND;
          FN_OR:   ALU_control = ALU_OR;
          FN_NOR:  ALU_control = ALU_NOR;
          FN_SLT:  ALU_control = ALU_SLT;
          default: ALU_control = ALU_ADD;
        endcase
      end
      default: ALU_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and select, plus the ALU operation code.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] ALU_control,
  output logic       instr_done,
  output logic       illegal
);

  state_t  state, next_state;
  alu_op_t alu_op;
  logic    pc_write, branch;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Outputs decode straight from the state register; reset gates them in the
  // same cycle so an interrupted instruction issues no partial writeback.
  always_comb begin
    next_state = S_FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    PCSrc      = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          IRWrite    = 1'b1;
          pc_write   = 1'b1;
          ALUSrcB    = SRCB_FOUR;
          next_state = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM_SHL2;
          if (!instr_supported(opcode, funct)) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end else begin
            case (opcode)
              OP_LW, OP_SW: next_state = S_MEMADR;
              OP_RTYPE:     next_state = S_EXEC;
              OP_BEQ:       next_state = S_BRANCH;
              OP_ADDI:      next_state = S_ADDIEX;
              default:      next_state = S_JUMP;
            endcase
          end
        end
        S_MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          IorD       = 1'b1;
          next_state = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA    = 1'b1;
          alu_op     = ALUOP_FUNCT;
          next_state = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          alu_op     = ALUOP_SUB;
          PCSrc      = PCSRC_ALUOUT;
          branch     = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDIEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          next_state = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          PCSrc      = PCSRC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

  assign PCEn = pc_write | (branch & zero);

  alu_decoder u_alu_decoder (
    .ALUOp       (alu_op),
    .funct       (funct),
    .ALU_control (ALU_control)
  );

endmodule
